// File: rtl/eject_packet_buffer_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// eject_packet_buffer_if
// Flit handshake between a router's local output port and the eject buffer.
//   in_flit  : 32-bit flit (dest X/Y, src X/Y, 2-bit type in [1:0])
//   in_valid : in_flit is valid this cycle
//   in_ready : receiver accepts the flit this cycle
// A flit moves on a rising edge where in_valid && in_ready.
//   master : router side (drives flit/valid)
//   slave  : eject buffer side (drives ready)
// ---------------------------------------------------------------------------
interface eject_packet_buffer_if;
    logic [31:0] in_flit;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_flit,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_flit,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/eject_packet_buffer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// eject_packet_buffer
// Collects one 8-flit packet (HEAD, 6 x BODY, TAIL) addressed to this node
// from the router local output. It checks the flit sequence and presents the
// completed packet in memory[0..7] for HOLD_CYC cycles with out_valid high.
// Misrouted or malformed packets are dropped and counted as errors.
//
// Ports
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   flit_if    : slave side of the flit handshake (in_flit/in_valid/in_ready)
//   memory     : assembled packet; memory[0] = HEAD, memory[7] = TAIL
//   address    : write pointer; 0 while a complete packet is presented
//   out_valid  : memory holds a complete, checked packet
//   pkt_done   : one-cycle pulse when a packet completes
//   err        : one-cycle pulse on any protocol error
//   pkt_cnt    : saturating count of completed packets
//   err_cnt    : saturating count of protocol errors
// ---------------------------------------------------------------------------
module eject_packet_buffer #(
    parameter logic [6:0] LOCAL_X  = 7'd0,
    parameter logic [6:0] LOCAL_Y  = 7'd0,
    parameter int         HOLD_CYC = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    eject_packet_buffer_if.slave flit_if,
    output logic [31:0]          memory [7:0],
    output logic [2:0]           address,
    output logic                 out_valid,
    output logic                 pkt_done,
    output logic                 err,
    output logic [15:0]          pkt_cnt,
    output logic [7:0]           err_cnt
);

    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        pkt_done_q, pkt_done_d;
    logic        err_q, err_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [31:0] mem_q [7:0];
    logic        wr_en;
    logic [2:0]  wr_addr;

    logic        xfer;
    logic [1:0]  ftype;
    logic        dest_match;
    logic        pkt_inc;
    logic        err_inc;

    // Source coordinates and spare bits are carried into memory but never
    // inspected by the control logic.
    logic        unused_flit_bits;
    assign unused_flit_bits = ^flit_if.in_flit[17:2];

    // Ready is withheld in HOLD so a following HEAD stalls rather than drops.
    assign flit_if.in_ready = (state_q != S_HOLD) && !rst;
    assign xfer       = flit_if.in_valid && flit_if.in_ready;
    assign ftype      = flit_if.in_flit[1:0];
    assign dest_match = (flit_if.in_flit[31:25] == LOCAL_X) &&
                        (flit_if.in_flit[24:18] == LOCAL_Y);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hold_cnt_d  = hold_cnt_q;
        out_valid_d = out_valid_q;
        pkt_done_d  = 1'b0;
        pkt_inc     = 1'b0;
        err_inc     = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = addr_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (ftype == T_HEAD && dest_match) begin
                        wr_en   = 1'b1;
                        wr_addr = 3'd0;
                        addr_d  = 3'd1;
                        state_d = S_RECV;
                    end else if (ftype == T_HEAD) begin
                        err_inc = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (xfer) begin
                    if (addr_q == 3'd7) begin
                        if (ftype == T_TAIL) begin
                            wr_en       = 1'b1;
                            addr_d      = 3'd0;
                            hold_cnt_d  = 8'd0;
                            out_valid_d = 1'b1;
                            pkt_done_d  = 1'b1;
                            pkt_inc     = 1'b1;
                            state_d     = S_HOLD;
                        end else begin
                            err_inc = 1'b1;
                            addr_d  = 3'd0;
                            state_d = S_DROP;
                        end
                    end else if (ftype == T_BODY) begin
                        wr_en  = 1'b1;
                        addr_d = addr_q + 3'd1;
                    end else if (ftype == T_TAIL) begin
                        // Short packet: the TAIL itself closes it, nothing to flush.
                        err_inc = 1'b1;
                        addr_d  = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        // HEAD or illegal type mid-packet: flush up to the next TAIL.
                        err_inc = 1'b1;
                        addr_d  = 3'd0;
                        state_d = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (xfer && ftype == T_TAIL) begin
                    addr_d  = 3'd0;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d  = 8'd0;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_d     = err_inc;
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (pkt_inc && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
        if (err_inc && err_cnt_q != 8'hFF)    err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 3'd0;
            hold_cnt_q  <= 8'd0;
            out_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= 16'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hold_cnt_q  <= hold_cnt_d;
            out_valid_q <= out_valid_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Packet storage is deliberately not reset; its contents only matter
    // while out_valid is high. No write can happen while rst is high because
    // in_ready is low then.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= flit_if.in_flit;
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_mem_out
        assign memory[gi] = mem_q[gi];
    end

    assign address   = addr_q;
    assign out_valid = out_valid_q;
    assign pkt_done  = pkt_done_q;
    assign err       = err_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/eject_packet_buffer.md
EJECT_PACKET_BUFFER -- requirements
Module: eject_packet_buffer

Interface
REQ-001 SHALL have parameter LOCAL_X, default 7'd0: X coordinate of this node.
REQ-002 SHALL have parameter LOCAL_Y, default 7'd0: Y coordinate of this node.
REQ-003 SHALL have parameter HOLD_CYC, default 7: cycles a completed packet is held stable; legal range 1..255.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_flit  input  32  flit from router local output: [31:25] dest X, [24:18] dest Y, [17:11] src X, [10:4] src Y, [1:0] type (2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 illegal).
REQ-007 SHALL have port in_valid  input  1  in_flit valid.
REQ-008 SHALL have port in_ready  output  1  block accepts flit this cycle.
REQ-009 SHALL have port memory  output  8x32 (unpacked [7:0])  assembled packet, memory[0] = HEAD.
REQ-010 SHALL have port address  output  3  write pointer; 0 when a complete packet is presented.
REQ-011 SHALL have port out_valid  output  1  memory holds a complete, checked packet.
REQ-012 SHALL have port pkt_done  output  1  one-cycle pulse on packet completion.
REQ-013 SHALL have port err  output  1  one-cycle pulse on any protocol error.
REQ-014 SHALL have ports pkt_cnt  output  16  and err_cnt  output  8: saturating counters.

Function
REQ-015 Transfer SHALL occur only on a rising edge where in_valid && in_ready.
REQ-016 FSM states SHALL be IDLE, RECV, DROP, HOLD; in_ready = 1 in IDLE/RECV/DROP, 0 in HOLD.
REQ-017 IDLE: accepted HEAD with dest == (LOCAL_X, LOCAL_Y) -> write memory[0], address <= 1, go RECV.
REQ-018 IDLE: accepted HEAD with dest mismatch -> err pulse, err_cnt+1, go DROP; memory unchanged.
REQ-019 IDLE: accepted BODY/TAIL/illegal -> discarded, err pulse, err_cnt+1, stay IDLE.
REQ-020 RECV, address 1..6: accepted BODY -> write memory[address], address+1.
REQ-021 RECV, address == 7: accepted TAIL -> write memory[7], address wraps to 0, go HOLD.
REQ-022 RECV: accepted HEAD, illegal type, TAIL at address < 7, or non-TAIL at address 7 -> err pulse, err_cnt+1, address <= 0, out_valid stays 0; non-TAIL at address 7 or HEAD -> go DROP; TAIL early -> go IDLE.
REQ-023 DROP: discard all flits; accepted TAIL -> IDLE, address = 0.
REQ-024 Entering HOLD: pkt_done and out_valid SHALL rise the cycle after the TAIL edge; pkt_cnt+1 on the same edge.
REQ-025 HOLD: out_valid = 1 for exactly HOLD_CYC cycles, memory and address (=0) stable; then IDLE with out_valid = 0.
REQ-026 Back-to-back: a HEAD presented during HOLD SHALL stall (not dropped) and be accepted in the first IDLE cycle.
REQ-027 in_valid low SHALL freeze state, address and memory in IDLE/RECV/DROP.
REQ-028 Memory contents SHALL be meaningful only while out_valid = 1.
REQ-029 Counters SHALL saturate at all-ones, never wrap.

Reset
REQ-030 rst SHALL force IDLE, address = 0, out_valid = 0, pkt_done = 0, err = 0, pkt_cnt = 0, err_cnt = 0, HOLD counter = 0; in_ready = 0 while rst high.
REQ-031 memory SHALL NOT be reset; entries remain X until first written.
REQ-032 rst asserted mid-packet or in HOLD SHALL abandon the packet; no pkt_done for it.

Verification
REQ-033 LOCAL=(0,0); HEAD 32'h0000_1812 (src 3,1), 6 BODY, TAIL, in_valid held high -> pkt_done 1 cycle after TAIL, out_valid 7 cycles, memory[0]=32'h0000_1812, pkt_cnt=1, address=0.
REQ-034 HEAD with dest X=5 while LOCAL_X=0, then 7 flits ending TAIL -> err pulse once, err_cnt=1, no pkt_done, IDLE after TAIL.
REQ-035 HEAD, 3 BODY, TAIL (5 flits) -> err at TAIL, address=0, out_valid never 1; next legal 8-flit packet completes normally.
REQ-036 Two packets back-to-back, in_valid constant 1 -> second HEAD stalled 7 cycles (in_ready=0), both complete, pkt_cnt=2.
REQ-037 rst asserted after 4 flits of a packet -> address=0, no pkt_done; following packet completes; memory[4..7] show new packet.
REQ-038 in_valid toggled randomly across a legal packet -> identical memory contents as REQ-033.
